// File: rtl/slavefifo2b_gpif_if_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : slavefifo2b_gpif_if_if                                      |
// | Description : FX3 Slave FIFO 2-bit pin bundle.                            |
// |               master modport = FPGA side (drives control/data pins)       |
// |               slave  modport = FX3 side (drives flags and read data)      |
// | Signals     : flaga, flagb        FX3 socket-ready / watermark flags      |
// |               slcs_, slwr_, slrd_, sloe_, pktend_  active-low controls    |
// |               faddr[1:0]          socket address                          |
// |               fdata_o/fdata_oe    FPGA bus drive data / enable            |
// |               fdata_i             sampled bus data                        |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
interface slavefifo2b_gpif_if_if;
    logic        flaga;
    logic        flagb;
    logic        slcs_;
    logic        slwr_;
    logic        slrd_;
    logic        sloe_;
    logic        pktend_;
    logic [1:0]  faddr;
    logic [31:0] fdata_o;
    logic        fdata_oe;
    logic [31:0] fdata_i;

    modport master (
        input  flaga, flagb, fdata_i,
        output slcs_, slwr_, slrd_, sloe_, pktend_, faddr, fdata_o, fdata_oe
    );

    modport slave (
        output flaga, flagb, fdata_i,
        input  slcs_, slwr_, slrd_, sloe_, pktend_, faddr, fdata_o, fdata_oe
    );
endinterface
`default_nettype wire

// File: rtl/slavefifo2b_gpif_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : slavefifo2b_gpif_if                                         |
// | Description : Pin-side stage between the FX3 Slave FIFO 2-bit bus and the |
// |               stream generators. Registers FX3 flags, selects the active  |
// |               stream mode with an idle gap between modes, registers the   |
// |               write/read strobes and data onto the pins, counts pin       |
// |               writes and flags write overruns against the watermark.      |
// | Ports       : clk_100, reset_ (async, active-low)                         |
// |               mode_req[1:0]       00 none, 01 in, 10 out, 11 none         |
// |               flaga_d, flagb_d    registered FX3 flags                    |
// |               stream_in/out_mode_selected  generator enables              |
// |               slwr_streamIN_, data_out_stream_in[31:0]  write side        |
// |               slrd_streamOUT_, sloe_streamOUT_          read side         |
// |               data_in_stream_out[31:0]  registered bus data               |
// |               wr_count[31:0]      pin writes since last mode select       |
// |               overrun_err, err_clr  sticky overrun error and its clear    |
// |               fx3                 FX3 pin bundle (master modport)         |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module slavefifo2b_gpif_if #(
    parameter int         GAP_CYCLES = 16,
    parameter logic [1:0] ADDR_IN    = 2'b00,
    parameter logic [1:0] ADDR_OUT   = 2'b11,
    parameter int         OVR_LIMIT  = 3
) (
    input  wire logic        clk_100,
    input  wire logic        reset_,
    input  wire logic [1:0]  mode_req,
    output logic             flaga_d,
    output logic             flagb_d,
    output logic             stream_in_mode_selected,
    output logic             stream_out_mode_selected,
    input  wire logic        slwr_streamIN_,
    input  wire logic [31:0] data_out_stream_in,
    input  wire logic        slrd_streamOUT_,
    input  wire logic        sloe_streamOUT_,
    output logic [31:0]      data_in_stream_out,
    output logic [31:0]      wr_count,
    output logic             overrun_err,
    input  wire logic        err_clr,
    slavefifo2b_gpif_if_if.master fx3
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam int OVR_W = $clog2(OVR_LIMIT + 2);

    localparam logic [GAP_W-1:0] c_GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [OVR_W-1:0] c_OVR_LIM  = OVR_W'(OVR_LIMIT);
    localparam logic [OVR_W-1:0] c_OVR_SAT  = OVR_W'(OVR_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAP    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Target encoding: 0 = stream-in (write socket), 1 = stream-out (read socket)
    localparam logic c_TGT_IN  = 1'b0;
    localparam logic c_TGT_OUT = 1'b1;

    // ------------------------------------------------------------------
    // State / register declarations
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic             tgt_q, tgt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic [1:0]       mode_q;
    logic             flaga_q, flagb_q;

    logic             sel_in_q, sel_in_d;
    logic             sel_out_q, sel_out_d;

    logic             slcs_q, slcs_d;
    logic             slwr_q, slwr_d;
    logic             slrd_q, slrd_d;
    logic             sloe_q, sloe_d;
    logic             fdata_oe_q, fdata_oe_d;
    logic [1:0]       faddr_q, faddr_d;
    logic [31:0]      fdata_o_q;
    logic [31:0]      data_in_q;

    logic [31:0]      wr_count_q, wr_count_d;
    logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;
    logic             ovr_err_q, ovr_err_d;

    // ------------------------------------------------------------------
    // Mode decode on the registered request (11 behaves as "none")
    // ------------------------------------------------------------------
    logic w_mode_in, w_mode_out, w_mode_is_tgt, w_idle_to_gap;
    logic w_in_en, w_out_en, w_ovr_viol, w_ovr_set;

    assign w_mode_in     = (mode_q == 2'b01);
    assign w_mode_out    = (mode_q == 2'b10);
    assign w_mode_is_tgt = (tgt_q == c_TGT_OUT) ? w_mode_out : w_mode_in;

    // Enables stay up through DRAIN so an in-flight burst reaches the pins.
    // A single target bit guarantees the two enables are mutually exclusive.
    assign w_in_en  = (tgt_q == c_TGT_IN)  &&
                      ((state_q == ST_ACTIVE) || (state_q == ST_DRAIN));
    assign w_out_en = (tgt_q == c_TGT_OUT) &&
                      ((state_q == ST_ACTIVE) || (state_q == ST_DRAIN));

    // ------------------------------------------------------------------
    // Mode-switch FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        gap_cnt_d     = gap_cnt_q;
        w_idle_to_gap = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (w_mode_in || w_mode_out) begin
                    state_d       = ST_GAP;
                    tgt_d         = w_mode_out ? c_TGT_OUT : c_TGT_IN;
                    gap_cnt_d     = c_GAP_LOAD;
                    w_idle_to_gap = 1'b1;
                end
            end
            ST_GAP: begin
                // A change of request during the gap abandons it before any
                // select is raised; IDLE then restarts the gap for the new mode.
                if (!w_mode_is_tgt) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!w_mode_is_tgt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave only when neither generator is mid-strobe.
                if (slwr_streamIN_ && slrd_streamOUT_) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            state_q   <= ST_IDLE;
            tgt_q     <= c_TGT_IN;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Pin, select and counter next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sel_in_d   = (state_q == ST_ACTIVE) && (tgt_q == c_TGT_IN);
        sel_out_d  = (state_q == ST_ACTIVE) && (tgt_q == c_TGT_OUT);

        slcs_d     = (state_q == ST_IDLE);
        slwr_d     = w_in_en  ? slwr_streamIN_  : 1'b1;
        slrd_d     = w_out_en ? slrd_streamOUT_ : 1'b1;
        sloe_d     = w_out_en ? sloe_streamOUT_ : 1'b1;
        fdata_oe_d = w_in_en;

        // Socket address may only move while no transfer can be in progress.
        faddr_d = faddr_q;
        if ((state_q == ST_IDLE) || (state_q == ST_GAP)) begin
            faddr_d = (tgt_q == c_TGT_OUT) ? ADDR_OUT : ADDR_IN;
        end

        // Count on the registered pin strobe so the count matches the bus.
        wr_count_d = wr_count_q;
        if (w_idle_to_gap) begin
            wr_count_d = '0;
        end else if (!slwr_q) begin
            wr_count_d = wr_count_q + 32'd1;
        end

        // Consecutive pin writes against a low watermark; the counter
        // saturates one past the limit so it cannot wrap back to legal.
        w_ovr_viol = !slwr_q && !flagb_q;
        w_ovr_set  = w_ovr_viol && (ovr_cnt_q >= c_OVR_LIM);
        ovr_cnt_d  = '0;
        if (w_ovr_viol) begin
            ovr_cnt_d = (ovr_cnt_q == c_OVR_SAT) ? ovr_cnt_q : ovr_cnt_q + 1'b1;
        end

        // A new violation wins over a coincident clear.
        ovr_err_d = ovr_err_q;
        if (w_ovr_set) begin
            ovr_err_d = 1'b1;
        end else if (err_clr) begin
            ovr_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            mode_q     <= 2'b00;
            flaga_q    <= 1'b0;
            flagb_q    <= 1'b0;
            sel_in_q   <= 1'b0;
            sel_out_q  <= 1'b0;
            slcs_q     <= 1'b1;
            slwr_q     <= 1'b1;
            slrd_q     <= 1'b1;
            sloe_q     <= 1'b1;
            fdata_oe_q <= 1'b0;
            faddr_q    <= ADDR_IN;
            fdata_o_q  <= '0;
            data_in_q  <= '0;
            wr_count_q <= '0;
            ovr_cnt_q  <= '0;
            ovr_err_q  <= 1'b0;
        end else begin
            mode_q     <= mode_req;
            flaga_q    <= fx3.flaga;
            flagb_q    <= fx3.flagb;
            sel_in_q   <= sel_in_d;
            sel_out_q  <= sel_out_d;
            slcs_q     <= slcs_d;
            slwr_q     <= slwr_d;
            slrd_q     <= slrd_d;
            sloe_q     <= sloe_d;
            fdata_oe_q <= fdata_oe_d;
            faddr_q    <= faddr_d;
            fdata_o_q  <= data_out_stream_in;
            data_in_q  <= fx3.fdata_i;
            wr_count_q <= wr_count_d;
            ovr_cnt_q  <= ovr_cnt_d;
            ovr_err_q  <= ovr_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign flaga_d                  = flaga_q;
    assign flagb_d                  = flagb_q;
    assign stream_in_mode_selected  = sel_in_q;
    assign stream_out_mode_selected = sel_out_q;
    assign data_in_stream_out       = data_in_q;
    assign wr_count                 = wr_count_q;
    assign overrun_err              = ovr_err_q;

    assign fx3.slcs_    = slcs_q;
    assign fx3.slwr_    = slwr_q;
    assign fx3.slrd_    = slrd_q;
    assign fx3.sloe_    = sloe_q;
    assign fx3.pktend_  = 1'b1;
    assign fx3.faddr    = faddr_q;
    assign fx3.fdata_o  = fdata_o_q;
    assign fx3.fdata_oe = fdata_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_slavefifo2b_gpif_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_slavefifo2b_gpif_if                                      |
// | Description : Self-checking bench for slavefifo2b_gpif_if. A vector table |
// |               covers flag/data registering and strobe gating while idle;  |
// |               hand-written sequences cover mode select timing, bursts,    |
// |               drain, overrun, async reset and gap abort.                  |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_slavefifo2b_gpif_if;

    logic        clk_100 = 1'b0;
    logic        reset_;
    logic [1:0]  mode_req;
    logic        flaga_d, flagb_d;
    logic        sel_in, sel_out;
    logic        slwr_in, slrd_in, sloe_in;
    logic [31:0] dout;
    logic [31:0] data_in_stream_out;
    logic [31:0] wr_count;
    logic        overrun_err;
    logic        err_clr;

    int errors = 0;
    int checks = 0;

    slavefifo2b_gpif_if_if bus ();

    slavefifo2b_gpif_if dut (
        .clk_100                  (clk_100),
        .reset_                   (reset_),
        .mode_req                 (mode_req),
        .flaga_d                  (flaga_d),
        .flagb_d                  (flagb_d),
        .stream_in_mode_selected  (sel_in),
        .stream_out_mode_selected (sel_out),
        .slwr_streamIN_           (slwr_in),
        .data_out_stream_in       (dout),
        .slrd_streamOUT_          (slrd_in),
        .sloe_streamOUT_          (sloe_in),
        .data_in_stream_out       (data_in_stream_out),
        .wr_count                 (wr_count),
        .overrun_err              (overrun_err),
        .err_clr                  (err_clr),
        .fx3                      (bus)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        logic        fa;
        logic        fb;
        logic [31:0] fdi;
        logic [31:0] dout;
        logic        swr;
        logic        srd;
        logic        soe;
        logic        exp_fa;
        logic        exp_fb;
        logic [31:0] exp_din;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0001, 32'h1111_1111, 1'b0, 1'b1, 1'b1,
                    1'b1, 1'b0, 32'h0000_0001, 32'h1111_1111};
        vecs[1] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 32'h2222_2222, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 32'hDEAD_BEEF, 32'h2222_2222};
        vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0,
                    1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 1'b0, 32'h5A5A_A5A5, 32'hA5A5_5A5A, 1'b0, 1'b1, 1'b1,
                    1'b1, 1'b0, 32'h5A5A_A5A5, 32'hA5A5_5A5A};

        reset_      = 1'b0;
        mode_req    = 2'b00;
        bus.flaga   = 1'b0;
        bus.flagb   = 1'b1;
        bus.fdata_i = 32'h0;
        slwr_in     = 1'b1;
        slrd_in     = 1'b1;
        sloe_in     = 1'b1;
        dout        = 32'h0;
        err_clr     = 1'b0;

        // ---------------- reset state ----------------
        #12;
        chk("rst_slcs",  32'(bus.slcs_), 32'd1);
        chk("rst_slwr",  32'(bus.slwr_), 32'd1);
        chk("rst_slrd",  32'(bus.slrd_), 32'd1);
        chk("rst_sloe",  32'(bus.sloe_), 32'd1);
        chk("rst_pktend", 32'(bus.pktend_), 32'd1);
        chk("rst_oe",    32'(bus.fdata_oe), 32'd0);
        chk("rst_faddr", 32'(bus.faddr), 32'd0);
        chk("rst_sel",   32'({sel_in, sel_out}), 32'd0);
        chk("rst_wrcnt", wr_count, 32'd0);
        chk("rst_ovr",   32'(overrun_err), 32'd0);
        @(negedge clk_100);
        reset_ = 1'b1;
        tick();

        // ---------------- idle vector table ----------------
        for (int i = 0; i < 5; i++) begin
            bus.flaga   = vecs[i].fa;
            bus.flagb   = vecs[i].fb;
            bus.fdata_i = vecs[i].fdi;
            dout        = vecs[i].dout;
            slwr_in     = vecs[i].swr;
            slrd_in     = vecs[i].srd;
            sloe_in     = vecs[i].soe;
            tick();
            chk("vec_flaga", 32'(flaga_d), 32'(vecs[i].exp_fa));
            chk("vec_flagb", 32'(flagb_d), 32'(vecs[i].exp_fb));
            chk("vec_din",   data_in_stream_out, vecs[i].exp_din);
            chk("vec_dout",  bus.fdata_o, vecs[i].exp_dout);
            chk("vec_slwr_gated", 32'(bus.slwr_), 32'd1);
            chk("vec_slrd_gated", 32'(bus.slrd_), 32'd1);
            chk("vec_sloe_gated", 32'(bus.sloe_), 32'd1);
            chk("vec_oe",    32'(bus.fdata_oe), 32'd0);
            chk("vec_slcs",  32'(bus.slcs_), 32'd1);
        end

        // ---------------- select stream-in: timing from t0 ----------------
        bus.flagb = 1'b1;
        slwr_in   = 1'b1;
        slrd_in   = 1'b1;
        sloe_in   = 1'b1;
        mode_req  = 2'b01;
        tick();                                  // edge t0 samples the request
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk("sel_in_rise", 32'(sel_in), 32'(k == 18));
            chk("sel_slcs",    32'(bus.slcs_), 32'(k < 2));
            chk("sel_oe",      32'(bus.fdata_oe), 32'(k >= 18));
            chk("sel_faddr",   32'(bus.faddr), 32'd0);
        end

        // ---------------- 8-word burst ----------------
        for (int j = 0; j < 8; j++) begin
            slwr_in = 1'b0;
            dout    = 32'(j);
            tick();
            chk("burst_slwr",  32'(bus.slwr_), 32'd0);
            chk("burst_data",  bus.fdata_o, 32'(j));
            chk("burst_count", wr_count, 32'(j));
        end
        slwr_in = 1'b1;
        tick();
        chk("burst_end_slwr",  32'(bus.slwr_), 32'd1);
        chk("burst_end_count", wr_count, 32'd8);

        // ---------------- deselect mid-burst: drain ----------------
        slwr_in  = 1'b0;
        dout     = 32'hA0;
        mode_req = 2'b00;
        tick();                                  // e0
        chk("drain_e0_sel", 32'(sel_in), 32'd1);
        tick();                                  // e1
        chk("drain_e1_sel", 32'(sel_in), 32'd1);
        tick();                                  // e2
        chk("drain_e2_sel",  32'(sel_in), 32'd0);
        chk("drain_e2_slwr", 32'(bus.slwr_), 32'd0);
        tick();                                  // e3
        chk("drain_e3_slwr", 32'(bus.slwr_), 32'd0);
        chk("drain_e3_slcs", 32'(bus.slcs_), 32'd0);
        slwr_in = 1'b1;
        tick();                                  // e4
        chk("drain_e4_slwr", 32'(bus.slwr_), 32'd1);
        chk("drain_e4_slcs", 32'(bus.slcs_), 32'd0);
        tick();                                  // e5
        chk("drain_idle_slcs", 32'(bus.slcs_), 32'd1);
        chk("drain_idle_oe",   32'(bus.fdata_oe), 32'd0);
        chk("drain_count",     wr_count, 32'd12);

        // ---------------- overrun ----------------
        bus.flagb = 1'b0;
        mode_req  = 2'b01;
        tick();
        repeat (18) tick();
        chk("ovr_sel",   32'(sel_in), 32'd1);
        chk("ovr_count_clr", wr_count, 32'd0);
        for (int f = 0; f < 5; f++) begin
            slwr_in = 1'b0;
            tick();
            chk("ovr_err_seq", 32'(overrun_err), 32'(f >= 4));
        end
        slwr_in = 1'b1;
        tick();
        chk("ovr_sticky", 32'(overrun_err), 32'd1);
        chk("ovr_count",  wr_count, 32'd5);
        err_clr = 1'b1;
        tick();
        chk("ovr_clear", 32'(overrun_err), 32'd0);
        // err_clr held high while a new overrun develops: set must win
        for (int g = 0; g < 5; g++) begin
            slwr_in = 1'b0;
            tick();
            if (g == 3) chk("ovr_clr_hold", 32'(overrun_err), 32'd0);
            if (g == 4) chk("ovr_set_wins", 32'(overrun_err), 32'd1);
        end
        err_clr = 1'b0;
        chk("pre_rst_slwr", 32'(bus.slwr_), 32'd0);

        // ---------------- async reset mid-ACTIVE ----------------
        #2;
        reset_ = 1'b0;
        #1;
        chk("arst_slwr",  32'(bus.slwr_), 32'd1);
        chk("arst_oe",    32'(bus.fdata_oe), 32'd0);
        chk("arst_slcs",  32'(bus.slcs_), 32'd1);
        chk("arst_sel",   32'({sel_in, sel_out}), 32'd0);
        chk("arst_count", wr_count, 32'd0);
        chk("arst_ovr",   32'(overrun_err), 32'd0);
        slwr_in   = 1'b1;
        bus.flagb = 1'b1;
        mode_req  = 2'b00;
        @(negedge clk_100);
        reset_ = 1'b1;
        tick();

        // ---------------- request change during GAP ----------------
        mode_req = 2'b01;
        tick();                                  // t0
        for (int k = 1; k <= 24; k++) begin
            if (k == 5) mode_req = 2'b10;
            tick();
            chk("abort_sel_in", 32'(sel_in), 32'd0);
            chk("abort_sel_out", 32'(sel_out), 32'(k >= 24));
            chk("abort_oe", 32'(bus.fdata_oe), 32'd0);
            if (k == 6) chk("abort_gap_slcs", 32'(bus.slcs_), 32'd0);
            if (k == 7) chk("abort_idle_slcs", 32'(bus.slcs_), 32'd1);
            if (k == 7) chk("abort_faddr_old", 32'(bus.faddr), 32'd0);
            if (k >= 8) chk("abort_faddr_out", 32'(bus.faddr), 32'd3);
        end

        // ---------------- stream-out strobes ----------------
        sloe_in     = 1'b0;
        slwr_in     = 1'b0;
        bus.fdata_i = 32'hCAFE_F00D;
        tick();
        chk("out_sloe",  32'(bus.sloe_), 32'd0);
        chk("out_slrd",  32'(bus.slrd_), 32'd1);
        chk("out_slwr_gated", 32'(bus.slwr_), 32'd1);
        chk("out_oe",    32'(bus.fdata_oe), 32'd0);
        chk("out_din",   data_in_stream_out, 32'hCAFE_F00D);
        slrd_in = 1'b0;
        tick();
        chk("out_slrd_low", 32'(bus.slrd_), 32'd0);
        chk("out_oe2",      32'(bus.fdata_oe), 32'd0);
        slrd_in = 1'b1;
        sloe_in = 1'b1;
        slwr_in = 1'b1;
        tick();
        chk("out_slrd_high", 32'(bus.slrd_), 32'd1);
        chk("out_sloe_high", 32'(bus.sloe_), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
